// File: rtl/pool_pkg.sv
// Shared constants and helpers for the 2x2/stride-2 pooling stage.
// Define POOL_AVG_EN to widen line-buffer entries to {pair sum, pair max} for average pooling.
package pool_pkg;

    localparam logic POOL_MODE_MAX = 1'b0;
    localparam logic POOL_MODE_AVG = 1'b1;

    localparam int LANE_MAX_W = 64;

    // Bits per lane in a line-buffer entry: the pair max, plus the DATA_W+1 pair sum when averaging.
    function automatic int pair_entry_w(input int data_w);
`ifdef POOL_AVG_EN
        return 2 * data_w + 1;
`else
        return data_w;
`endif
    endfunction

    function automatic logic signed [LANE_MAX_W-1:0] lane_max(
        input logic signed [LANE_MAX_W-1:0] a,
        input logic signed [LANE_MAX_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Single-port line buffer holding one horizontal pair entry per output column.
// The read is combinational so an odd-row pixel can combine with its stored pair in the same cycle.
module pool_line_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/pool2x2_stream.sv
// 2x2/stride-2 streaming pooling stage: max always, average selectable per frame when POOL_AVG_EN is defined.
// Even rows store horizontal pair results in the line buffer; odd rows combine and emit one result per window.
module pool2x2_stream
    import pool_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int CH       = 1,
    parameter int MAX_COLS = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 frame_start_in,
    input  logic                 line_start_in,
    input  logic                 frame_end_in,
    input  logic [CH*DATA_W-1:0] sig_layer,
    input  logic                 mode,
    output logic [CH*DATA_W-1:0] max_layer,
    output logic                 valid,
    output logic                 frame_start_out,
    output logic                 line_start_out,
    output logic                 frame_end_out,
    output logic                 err_overflow
);

    localparam int COL_W = $clog2(MAX_COLS) + 1;
    localparam int DEPTH = MAX_COLS / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW    = pair_entry_w(DATA_W);
    localparam int BW    = CH * EW;

    logic                 active_q, active_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic                 parity_q, parity_d;
    logic                 first_q, first_d;
    logic                 rowfirst_q, rowfirst_d;
    logic [CH*DATA_W-1:0] h_q, h_d;
    logic [CH*DATA_W-1:0] res_q, res_d;
    logic                 valid_q, valid_d;
    logic                 fso_q, fso_d;
    logic                 lso_q, lso_d;
    logic                 feo_q, feo_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 over;
    logic                 parity_eff;
    logic [COL_W-1:0]     col_eff;
    logic                 buf_we;
    logic [AW-1:0]        buf_addr;
    logic [BW-1:0]        wr_entry;
    logic [BW-1:0]        rd_entry;
    logic [CH*DATA_W-1:0] win_res;

`ifdef POOL_AVG_EN
    logic mode_q, mode_d;
`else
    logic unused_mode;
    assign unused_mode = mode;
`endif

    // Position of the current pixel once its line/frame markers are applied.
    assign accept     = ena & (active_q | frame_start_in);
    assign col_eff    = (frame_start_in | line_start_in) ? '0 : col_q;
    assign parity_eff = frame_start_in ? 1'b0 : (line_start_in ? ~parity_q : parity_q);
    assign over       = (col_eff >= COL_W'(MAX_COLS));
    assign buf_addr   = AW'(col_eff >> 1);

    for (genvar l = 0; l < CH; l++) begin : g_lane
        logic signed [DATA_W-1:0] px, hv, pmax, bmax, wmax;

        assign px   = sig_layer[l*DATA_W +: DATA_W];
        assign hv   = h_q[l*DATA_W +: DATA_W];
        assign pmax = DATA_W'(lane_max(LANE_MAX_W'(px), LANE_MAX_W'(hv)));
        assign bmax = rd_entry[l*EW +: DATA_W];
        assign wmax = DATA_W'(lane_max(LANE_MAX_W'(pmax), LANE_MAX_W'(bmax)));

`ifdef POOL_AVG_EN
        logic signed [DATA_W:0]   psum, bsum;
        logic signed [DATA_W+1:0] wsum;

        assign psum = (DATA_W+1)'(px) + (DATA_W+1)'(hv);
        assign bsum = rd_entry[l*EW+DATA_W +: DATA_W+1];
        assign wsum = (DATA_W+2)'(psum) + (DATA_W+2)'(bsum);
        assign wr_entry[l*EW +: EW] = {psum, pmax};
        assign win_res[l*DATA_W +: DATA_W] =
            (mode_q == POOL_MODE_AVG) ? DATA_W'(wsum >>> 2) : wmax;
`else
        assign wr_entry[l*EW +: EW]        = pmax;
        assign win_res[l*DATA_W +: DATA_W] = wmax;
`endif
    end

    pool_line_buf #(
        .WIDTH(BW),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_line_buf (
        .clk  (clk),
        .we   (buf_we),
        .addr (buf_addr),
        .wdata(wr_entry),
        .rdata(rd_entry)
    );

    always_comb begin
        active_d   = active_q;
        col_d      = col_q;
        parity_d   = parity_q;
        first_d    = first_q;
        rowfirst_d = rowfirst_q;
        h_d        = h_q;
        res_d      = res_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        fso_d      = 1'b0;
        lso_d      = 1'b0;
        feo_d      = 1'b0;
        buf_we     = 1'b0;
`ifdef POOL_AVG_EN
        mode_d     = mode_q;
`endif
        if (accept) begin
            if (frame_start_in) begin
                active_d = 1'b1;
                first_d  = 1'b1;
                err_d    = 1'b0;
`ifdef POOL_AVG_EN
                mode_d   = mode;
`endif
            end
            if (frame_start_in || line_start_in) begin
                rowfirst_d = 1'b1;
            end
            parity_d = parity_eff;
            // Pixels beyond the line buffer are dropped; col stays put so it cannot wrap.
            if (over) begin
                err_d = 1'b1;
                col_d = col_eff;
            end else begin
                col_d = col_eff + COL_W'(1);
                if (!col_eff[0]) begin
                    h_d = sig_layer;
                end else if (!parity_eff) begin
                    buf_we = 1'b1;
                end else begin
                    res_d      = win_res;
                    valid_d    = 1'b1;
                    fso_d      = first_d;
                    lso_d      = rowfirst_d;
                    first_d    = 1'b0;
                    rowfirst_d = 1'b0;
                end
            end
            if (frame_end_in) begin
                active_d = 1'b0;
                feo_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            col_q      <= '0;
            parity_q   <= 1'b0;
            first_q    <= 1'b0;
            rowfirst_q <= 1'b0;
            h_q        <= '0;
            res_q      <= '0;
            valid_q    <= 1'b0;
            fso_q      <= 1'b0;
            lso_q      <= 1'b0;
            feo_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef POOL_AVG_EN
            mode_q     <= POOL_MODE_MAX;
`endif
        end else begin
            active_q   <= active_d;
            col_q      <= col_d;
            parity_q   <= parity_d;
            first_q    <= first_d;
            rowfirst_q <= rowfirst_d;
            h_q        <= h_d;
            res_q      <= res_d;
            valid_q    <= valid_d;
            fso_q      <= fso_d;
            lso_q      <= lso_d;
            feo_q      <= feo_d;
            err_q      <= err_d;
`ifdef POOL_AVG_EN
            mode_q     <= mode_d;
`endif
        end
    end

    assign max_layer       = res_q;
    assign valid           = valid_q;
    assign frame_start_out = fso_q;
    assign line_start_out  = lso_q;
    assign frame_end_out   = feo_q;
    assign err_overflow    = err_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Scoreboard bench for pool2x2_stream (CH=2, MAX_COLS=8): expected windows come from a frame array.
// Average expectations apply only when POOL_AVG_EN is defined; otherwise mode=1 must still yield max.
module tb_pool2x2_stream;

    localparam int DATA_W   = 16;
    localparam int CH       = 2;
    localparam int MAX_COLS = 8;
`ifdef POOL_AVG_EN
    localparam bit AVG_ON = 1'b1;
`else
    localparam bit AVG_ON = 1'b0;
`endif

    typedef struct {
        logic [CH*DATA_W-1:0] data;
        logic                 v;
        logic                 fs;
        logic                 ls;
        logic                 fe;
    } expT;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 ena = 1'b0;
    logic                 frame_start_in = 1'b0;
    logic                 line_start_in = 1'b0;
    logic                 frame_end_in = 1'b0;
    logic [CH*DATA_W-1:0] sig_layer = '0;
    logic                 mode = 1'b0;
    logic [CH*DATA_W-1:0] max_layer;
    logic                 valid;
    logic                 frame_start_out;
    logic                 line_start_out;
    logic                 frame_end_out;
    logic                 err_overflow;

    expT expQ[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  fr0 [4][12];
    int  fr1 [4][12];

    pool2x2_stream #(
        .DATA_W  (DATA_W),
        .CH      (CH),
        .MAX_COLS(MAX_COLS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .frame_start_in (frame_start_in),
        .line_start_in  (line_start_in),
        .frame_end_in   (frame_end_in),
        .sig_layer      (sig_layer),
        .mode           (mode),
        .max_layer      (max_layer),
        .valid          (valid),
        .frame_start_out(frame_start_out),
        .line_start_out (line_start_out),
        .frame_end_out  (frame_end_out),
        .err_overflow   (err_overflow)
    );

    always #5 clk = ~clk;

    function automatic int expLane(input int a, input int b, input int c, input int d, input bit avg);
        int s, q, m;
        if (avg) begin
            s = a + b + c + d;
            q = s / 4;
            if (s < 0 && (s % 4) != 0) q = q - 1;
            return q;
        end
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic checkOutput();
        expT e;
        compared++;
        assert (expQ.size() != 0) else begin
            mismatched++;
            $error("[TB] FAIL spurious_output valid=%0b frame_end_out=%0b expected=none", valid, frame_end_out);
        end
        if (expQ.size() == 0) return;
        e = expQ.pop_front();
        compared++;
        assert (valid === e.v) else begin
            mismatched++;
            $error("[TB] FAIL valid observed=%0b expected=%0b", valid, e.v);
        end
        if (e.v) begin
            compared++;
            assert (max_layer === e.data) else begin
                mismatched++;
                $error("[TB] FAIL max_layer observed=%h expected=%h", max_layer, e.data);
            end
        end
        compared++;
        assert (frame_start_out === e.fs) else begin
            mismatched++;
            $error("[TB] FAIL frame_start_out observed=%0b expected=%0b", frame_start_out, e.fs);
        end
        compared++;
        assert (line_start_out === e.ls) else begin
            mismatched++;
            $error("[TB] FAIL line_start_out observed=%0b expected=%0b", line_start_out, e.ls);
        end
        compared++;
        assert (frame_end_out === e.fe) else begin
            mismatched++;
            $error("[TB] FAIL frame_end_out observed=%0b expected=%0b", frame_end_out, e.fe);
        end
    endtask

    // Any valid or frame_end_out pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (valid === 1'b1 || frame_end_out === 1'b1) checkOutput();
    end

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        compared++;
        assert (max_layer === '0) else begin
            mismatched++;
            $error("[TB] FAIL %s_max_layer observed=%h expected=0", tag, max_layer);
        end
        checkBit({tag, "_valid"}, valid, 1'b0);
        checkBit({tag, "_fso"}, frame_start_out, 1'b0);
        checkBit({tag, "_lso"}, line_start_out, 1'b0);
        checkBit({tag, "_feo"}, frame_end_out, 1'b0);
        checkBit({tag, "_err"}, err_overflow, 1'b0);
    endtask

    task automatic applyStimulus(input bit fs, input bit ls, input bit fe, input bit md,
                                 input logic [CH*DATA_W-1:0] px);
        @(negedge clk);
        ena            = 1'b1;
        frame_start_in = fs;
        line_start_in  = ls;
        frame_end_in   = fe;
        mode           = md;
        sig_layer      = px;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ena            = 1'b0;
            frame_start_in = 1'b0;
            line_start_in  = 1'b0;
            frame_end_in   = 1'b0;
        end
    endtask

    // Idle cycles carrying junk sideband and data that must be ignored.
    task automatic insertGap();
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            ena            = 1'b0;
            frame_start_in = 1'($urandom_range(0, 1));
            line_start_in  = 1'($urandom_range(0, 1));
            frame_end_in   = 1'($urandom_range(0, 1));
            sig_layer      = {$urandom, $urandom};
        end
    endtask

    task automatic fillRamp(input int R, input int C);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                fr0[r][c] = r * C + c;
                fr1[r][c] = 50 - 7 * (r * C + c);
            end
    endtask

    task automatic sendFrame(input int R, input int C, input int lastC, input bit md,
                             input bit gaps, input int stopAfter);
        int  n, rc;
        bit  firstWin, last, avg;
        expT e;
        n = 0;
        firstWin = 1'b1;
        avg = md && AVG_ON;
        for (int r = 0; r < R; r++) begin
            rc = (r == R - 1) ? lastC : C;
            for (int c = 0; c < rc; c++) begin
                if (stopAfter >= 0 && n >= stopAfter) return;
                n++;
                last = (r == R - 1) && (c == rc - 1);
                e.data = '0; e.v = 1'b0; e.fs = 1'b0; e.ls = 1'b0; e.fe = last;
                if ((r % 2) == 1 && (c % 2) == 1 && c < MAX_COLS) begin
                    e.v  = 1'b1;
                    e.fs = firstWin;
                    e.ls = (c == 1);
                    firstWin = 1'b0;
                    e.data = {16'(expLane(fr1[r-1][c-1], fr1[r-1][c], fr1[r][c-1], fr1[r][c], avg)),
                              16'(expLane(fr0[r-1][c-1], fr0[r-1][c], fr0[r][c-1], fr0[r][c], avg))};
                end
                if (e.v || e.fe) expQ.push_back(e);
                if (gaps) insertGap();
                applyStimulus(r == 0 && c == 0, c == 0, last, md, {16'(fr1[r][c]), 16'(fr0[r][c])});
            end
        end
    endtask

    // Pixels with no frame_start_in while idle; nothing may come out.
    task automatic sendOrphans(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, i == 0, 1'b0, 1'b0, {16'(i + 3), 16'(i + 40)});
    endtask

    initial begin
        $display("[TB] pool2x2_stream bench, average compiled in = %0b", AVG_ON);
        idle(3);
        checkAllZero("reset");
        rst_n = 1'b1;
        idle(2);

        fillRamp(4, 4);
        sendFrame(4, 4, 4, 1'b0, 1'b0, -1);
        idle(2);
        sendOrphans(4);
        idle(3);

        sendFrame(4, 4, 4, 1'b1, 1'b0, -1);
        idle(3);

        fillRamp(3, 5);
        sendFrame(3, 5, 5, 1'b0, 1'b0, -1);
        idle(3);

        fr0[0][0] = -1; fr0[0][1] = -2; fr0[1][0] = -3; fr0[1][1] = -4;
        fr1[0][0] =  7; fr1[0][1] =  3; fr1[1][0] =  9; fr1[1][1] =  1;
        sendFrame(2, 2, 2, 1'b0, 1'b0, -1);
        idle(2);
        sendFrame(2, 2, 2, 1'b1, 1'b0, -1);
        idle(3);

        fillRamp(3, MAX_COLS + 2);
        sendFrame(3, MAX_COLS + 2, 1, 1'b0, 1'b0, -1);
        idle(4);
        checkBit("err_overflow_sticky", err_overflow, 1'b1);
        begin
            expT e;
            e.data = '0; e.v = 1'b0; e.fs = 1'b0; e.ls = 1'b0; e.fe = 1'b1;
            expQ.push_back(e);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, {16'(11), 16'(22)});
        idle(1);
        checkBit("err_overflow_cleared", err_overflow, 1'b0);
        idle(2);

        fillRamp(4, 4);
        sendFrame(4, 4, 4, 1'b0, 1'b1, -1);
        idle(3);
        sendFrame(4, 4, 4, 1'b1, 1'b1, -1);
        idle(3);

        sendFrame(4, 4, 4, 1'b0, 1'b0, 6);
        @(negedge clk);
        rst_n = 1'b0;
        ena   = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        rst_n = 1'b1;
        sendOrphans(10);
        idle(3);
        sendFrame(4, 4, 4, 1'b0, 1'b0, -1);
        idle(5);

        compared++;
        assert (expQ.size() == 0) else begin
            mismatched++;
            $error("[TB] FAIL scoreboard_drained observed=%0d pending expected=0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
